// File: rtl/fpu_mult_pkg.sv
// Shared definitions for the FP multiplier datapath: exponent widths,
// bias helper and the exponent classification used by the finalisation stage.
package fpu_mult_pkg;

  localparam int EW_SP = 8;
  localparam int EW_DP = 11;

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  typedef enum logic [1:0] {
    EXP_NORMAL = 2'd0,
    EXP_ZERO   = 2'd1,
    EXP_OVF    = 2'd2,
    EXP_UNF    = 2'd3
  } exp_class_t;

endpackage

// File: rtl/mult_exp_check_stage_pipe_slice.sv
// One-entry valid/ready register slice; accepts whenever empty or draining,
// so back-to-back transfers run at full rate.
module pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/mult_exp_check_stage.sv
// Exponent finalisation: adds the normalisation increment, classifies
// overflow/underflow, saturates and hands the result on through two slices.
module mult_exp_check_stage
  import fpu_mult_pkg::*;
#(
  parameter int EW = EW_SP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [EW+1:0] Exp_S_i,
  input  logic          Norm_inc_i,
  input  logic          Zero_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [EW-1:0] Exp_o,
  output logic          Overflow_o,
  output logic          Underflow_o,
  output logic          Ovf_sticky_o,
  output logic          Unf_sticky_o
);

  localparam int AW = EW + 3;
  localparam logic signed [AW-1:0] OVF_LIM  = AW'((1 << EW) - 1);
  localparam logic signed [AW-1:0] ZERO_ADJ = '0;

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; ready never depends on the same-side valid.
  logic signed [AW-1:0] adj_in;
  logic [AW:0]          s1_in_data;
  logic [AW:0]          s1_data;
  logic                 s1_valid;
  logic                 s2_ready;
  logic signed [AW-1:0] s1_adj;
  logic                 s1_zero;

  // Extra sign bit keeps the +1 from wrapping at the top of the input range.
  assign adj_in     = AW'($signed(Exp_S_i)) + AW'(Norm_inc_i);
  assign s1_in_data = {Zero_i, adj_in};

  pipe_slice #(.W(AW + 1)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign s1_zero = s1_data[AW];
  assign s1_adj  = s1_data[AW-1:0];

  exp_class_t      cls;
  logic [EW-1:0]   exp_nxt;
  logic            ovf_nxt;
  logic            unf_nxt;
  logic [EW+1:0]   s2_in_data;
  logic [EW+1:0]   s2_data;

  always_comb begin
    cls     = EXP_NORMAL;
    exp_nxt = s1_adj[EW-1:0];
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    if (s1_zero)                  cls = EXP_ZERO;
    else if (s1_adj >= OVF_LIM)   cls = EXP_OVF;
    else if (s1_adj <= ZERO_ADJ)  cls = EXP_UNF;
    case (cls)
      EXP_ZERO: exp_nxt = '0;
      EXP_OVF: begin
        exp_nxt = '1;
        ovf_nxt = 1'b1;
      end
      EXP_UNF: begin
        exp_nxt = '0;
        unf_nxt = 1'b1;
      end
      default: exp_nxt = s1_adj[EW-1:0];
    endcase
  end

  assign s2_in_data = {exp_nxt, ovf_nxt, unf_nxt};

  pipe_slice #(.W(EW + 2)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in_data),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (s2_data)
  );

  assign Exp_o       = s2_data[EW+1:2];
  assign Overflow_o  = s2_data[1];
  assign Underflow_o = s2_data[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      Ovf_sticky_o <= 1'b0;
      Unf_sticky_o <= 1'b0;
    end else if (out_valid_o && out_ready_i) begin
      Ovf_sticky_o <= Ovf_sticky_o | Overflow_o;
      Unf_sticky_o <= Unf_sticky_o | Underflow_o;
    end
  end

endmodule
